button_debouncer: RTL

//  Front end for the parking meter's push-buttons. Each raw, asynchronous button line is

---
 rtl/button_debouncer.sv | 108 ++++++++++
 1 files changed

// File: rtl/button_debouncer.sv
// Push-button front end: per-channel 2-flop synchronizer followed by a
// debounce FSM that only accepts a level after it has been stable long enough.
module button_debouncer #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_clean,
  output logic [NUM_BUTTONS-1:0] btn_changed
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_PEND_HIGH,
    ST_HIGH,
    ST_PEND_LOW
  } state_t;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
      logic             r_s1;
      logic             r_s2;
      state_t           r_state;
      state_t           w_state_next;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             r_clean;
      logic             w_clean_next;
      logic             r_changed;
      logic             w_changed_next;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1      <= 1'b0;
          r_s2      <= 1'b0;
          r_state   <= ST_LOW;
          r_cnt     <= '0;
          r_clean   <= 1'b0;
          r_changed <= 1'b0;
        end else begin
          r_s1      <= btn_raw[gi];
          r_s2      <= r_s1;
          r_state   <= w_state_next;
          r_cnt     <= w_cnt_next;
          r_clean   <= w_clean_next;
          r_changed <= w_changed_next;
        end
      end

      // A single opposite sample in a pending state abandons qualification.
      always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_clean_next   = r_clean;
        w_changed_next = 1'b0;
        case (r_state)
          ST_LOW: begin
            if (r_s2) begin
              w_state_next = ST_PEND_HIGH;
              w_cnt_next   = '0;
            end
          end
          ST_PEND_HIGH: begin
            if (!r_s2) begin
              w_state_next = ST_LOW;
            end else if (r_cnt == CNT_MAX) begin
              w_state_next   = ST_HIGH;
              w_clean_next   = 1'b1;
              w_changed_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          ST_HIGH: begin
            if (!r_s2) begin
              w_state_next = ST_PEND_LOW;
              w_cnt_next   = '0;
            end
          end
          ST_PEND_LOW: begin
            if (r_s2) begin
              w_state_next = ST_HIGH;
            end else if (r_cnt == CNT_MAX) begin
              w_state_next   = ST_LOW;
              w_clean_next   = 1'b0;
              w_changed_next = 1'b1;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
          default: begin
            w_state_next = ST_LOW;
          end
        endcase
      end

      assign btn_clean[gi]   = r_clean;
      assign btn_changed[gi] = r_changed;
    end
  endgenerate

endmodule
